// File: rtl/me_pkg.sv
// Shared types and defaults for the motion-estimation window slicer family.
// Pure declarations: no latency, no flow control.
package me_pkg;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam int PIX_W_DEF = 1;
  localparam int WIN_W_DEF = 16;
  localparam int NPOS_DEF  = 8;
  localparam int ROWS_DEF  = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/me_window_slicer_if.sv
// Row-in / windowed-row-out stream pair between the fetch buffer and the AD array.
// Valid/ready on both sides; the slave modport is the slicer itself.
interface me_window_slicer_if
  import me_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int WIN_W = WIN_W_DEF,
  parameter int NPOS  = NPOS_DEF,
  parameter int ROWS  = ROWS_DEF
);
  localparam int SEG_W = WIN_W + NPOS - 1;
  localparam int IDX_W = clog2(ROWS);

  logic                        in_valid_i;
  logic                        in_ready_o;
  logic [SEG_W*PIX_W-1:0]      in_row_i;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [NPOS*WIN_W*PIX_W-1:0] out_win_o;
  logic [IDX_W-1:0]            out_row_o;
  logic                        out_last_o;

  modport slave (
    input  in_valid_i, in_row_i, out_ready_i,
    output in_ready_o, out_valid_o, out_win_o, out_row_o, out_last_o
  );

  modport master (
    output in_valid_i, in_row_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_win_o, out_row_o, out_last_o
  );

endinterface

// File: rtl/me_row_slicer.sv
// Combinational split of one row segment into NPOS overlapping WIN_W-element windows.
// Zero latency, no flow control; window p takes elements [p+WIN_W-1:p].
module me_row_slicer
  import me_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int WIN_W = WIN_W_DEF,
  parameter int NPOS  = NPOS_DEF
) (
  input  logic [(WIN_W+NPOS-1)*PIX_W-1:0] row_i,
  output logic [NPOS*WIN_W*PIX_W-1:0]     win_o
);

  for (genvar p = 0; p < NPOS; p++) begin : g_pos
    assign win_o[p*WIN_W*PIX_W +: WIN_W*PIX_W] = row_i[p*PIX_W +: WIN_W*PIX_W];
  end

endmodule

// File: rtl/me_window_slicer.sv
// Circular row buffer that gathers ROWS rows, then replays them as windowed rows.
// Output valid 1 cycle after the completing input beat; input stalls while a block is emitted.
module me_window_slicer
  import me_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int WIN_W = WIN_W_DEF,
  parameter int NPOS  = NPOS_DEF,
  parameter int ROWS  = ROWS_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_slide_i,
  input  logic               flush_i,
  me_window_slicer_if.slave  bus,
  output logic [15:0]        blk_cnt_o
);

  localparam int SEG_W    = WIN_W + NPOS - 1;
  localparam int ROW_BITS = SEG_W * PIX_W;
  localparam int PTR_W    = clog2(ROWS);
  localparam int CNT_W    = clog2(ROWS + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROWS - 1);
  localparam logic [PTR_W:0]   ROWS_EXT = (PTR_W + 1)'(ROWS);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rd_head_q, rd_head_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [15:0]         blk_cnt_q, blk_cnt_d;
  logic [ROW_BITS-1:0] mem_q [ROWS];
  logic [ROW_BITS-1:0] mem_d [ROWS];

  logic                in_ready;
  logic                out_valid;
  logic                in_hs;
  logic                out_hs;
  logic [PTR_W:0]      rd_sum;
  logic [PTR_W-1:0]    rd_idx;

  assign in_ready  = !rst_i && !flush_i && (state_q == FILL);
  assign out_valid = !rst_i && (state_q == EMIT);
  assign in_hs     = bus.in_valid_i && in_ready;
  assign out_hs    = out_valid && bus.out_ready_i;

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_row_o   = rst_i ? '0 : idx_q;
  assign bus.out_last_o  = out_valid && (idx_q == PTR_LAST);
  assign blk_cnt_o       = blk_cnt_q;

  // Wrap by compare so ROWS need not be a power of two.
  always_comb begin
    rd_sum = {1'b0, rd_head_q} + {1'b0, idx_q};
    rd_idx = rd_sum[PTR_W-1:0];
    if (rd_sum >= ROWS_EXT) begin
      rd_idx = PTR_W'(rd_sum - ROWS_EXT);
    end
  end

  me_row_slicer #(
    .PIX_W (PIX_W),
    .WIN_W (WIN_W),
    .NPOS  (NPOS)
  ) u_row_slicer (
    .row_i (mem_q[rd_idx]),
    .win_o (bus.out_win_o)
  );

  always_comb begin
    state_d   = state_q;
    rd_head_d = rd_head_q;
    wr_ptr_d  = wr_ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    blk_cnt_d = blk_cnt_q;
    mem_d     = mem_q;

    if (flush_i) begin
      state_d   = FILL;
      rd_head_d = '0;
      wr_ptr_d  = '0;
      idx_d     = '0;
      cnt_d     = '0;
      blk_cnt_d = '0;
    end else if (state_q == FILL) begin
      if (in_hs) begin
        mem_d[wr_ptr_q] = bus.in_row_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
        cnt_d           = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = EMIT;
          idx_d   = '0;
        end
      end
    end else if (out_hs) begin
      if (idx_q == PTR_LAST) begin
        state_d   = FILL;
        idx_d     = '0;
        blk_cnt_d = blk_cnt_q + 16'd1;
        // Sliding keeps the newest ROWS-1 rows, so one fresh row closes the next block.
        if (cfg_slide_i) begin
          rd_head_d = ptr_inc(rd_head_q);
          cnt_d     = CNT_LAST;
        end else begin
          rd_head_d = wr_ptr_q;
          cnt_d     = '0;
        end
      end else begin
        idx_d = ptr_inc(idx_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FILL;
      rd_head_q <= '0;
      wr_ptr_q  <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      blk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_head_q <= rd_head_d;
      wr_ptr_q  <= wr_ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_me_window_slicer.sv
// Directed bench for me_window_slicer: default instance plus a ROWS=5/NPOS=4/PIX_W=8 instance.
module tb_me_window_slicer;

  logic        clk = 1'b0;
  logic        rst;
  logic        slide;
  logic        flush;
  logic [15:0] blk_a;
  logic [15:0] blk_b;

  int checks   = 0;
  int failures = 0;

  logic [15:0]  exp_w0 [8];
  logic         t1_flag;
  logic [151:0] rowb;
  logic [127:0] expw0;
  logic [127:0] expw3;

  always #5 clk = ~clk;

  me_window_slicer_if ifa ();
  me_window_slicer_if #(.PIX_W(8), .WIN_W(16), .NPOS(4), .ROWS(5)) ifb ();

  me_window_slicer u_a (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_slide_i (slide),
    .flush_i     (flush),
    .bus         (ifa),
    .blk_cnt_o   (blk_a)
  );

  me_window_slicer #(.PIX_W(8), .WIN_W(16), .NPOS(4), .ROWS(5)) u_b (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_slide_i (1'b0),
    .flush_i     (1'b0),
    .bus         (ifb),
    .blk_cnt_o   (blk_b)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [22:0] r);
    ifa.in_valid_i = 1'b1;
    ifa.in_row_i   = r;
    step();
    ifa.in_valid_i = 1'b0;
  endtask

  task automatic emit_a();
    ifa.out_ready_i = 1'b1;
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      chk("a_out_valid", 512'(ifa.out_valid_o), 512'(1));
      chk("a_out_row", 512'(ifa.out_row_o), 512'(r));
      chk("a_out_last", 512'(ifa.out_last_o), 512'(r == 7));
      chk("a_win0", 512'(ifa.out_win_o[15:0]), 512'(exp_w0[r]));
      chk("a_in_ready_emit", 512'(ifa.in_ready_o), 512'(0));
      if (t1_flag && r == 3) begin
        chk("t1_row3_windows", 512'(ifa.out_win_o),
            512'(128'h0000_0000_0000_0000_0001_0002_0004_0008));
      end
      step();
    end
    @(negedge clk);
    chk("a_valid_after_block", 512'(ifa.out_valid_o), 512'(0));
  endtask

  initial begin
    rst = 1'b1; slide = 1'b0; flush = 1'b0; t1_flag = 1'b0;
    ifa.in_valid_i = 1'b0; ifa.in_row_i = '0; ifa.out_ready_i = 1'b0;
    ifb.in_valid_i = 1'b0; ifb.in_row_i = '0; ifb.out_ready_i = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("rst_out_valid", 512'(ifa.out_valid_o), 512'(0));
    chk("rst_in_ready", 512'(ifa.in_ready_o), 512'(0));
    chk("rst_out_last", 512'(ifa.out_last_o), 512'(0));
    chk("rst_out_row", 512'(ifa.out_row_o), 512'(0));
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("post_rst_blk_cnt", 512'(blk_a), 512'(0));
    chk("post_rst_in_ready", 512'(ifa.in_ready_o), 512'(1));

    // T1: one-hot rows, block mode.
    t1_flag = 1'b1;
    for (int k = 0; k < 8; k++) exp_w0[k] = 16'(1) << k;
    for (int k = 0; k < 7; k++) send_a(23'(1) << k);
    @(negedge clk);
    chk("t1_no_valid_before_last", 512'(ifa.out_valid_o), 512'(0));
    send_a(23'(1) << 7);
    emit_a();
    t1_flag = 1'b0;
    chk("t1_blk_cnt", 512'(blk_a), 512'(1));
    chk("t1_in_ready_after", 512'(ifa.in_ready_o), 512'(1));

    // T2: 5-cycle stall on row 2.
    for (int k = 0; k < 8; k++) send_a(23'(1) << (k + 8));
    ifa.out_ready_i = 1'b1;
    step();
    step();
    ifa.out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_stall_valid", 512'(ifa.out_valid_o), 512'(1));
      chk("t2_stall_row", 512'(ifa.out_row_o), 512'(2));
      chk("t2_stall_win0", 512'(ifa.out_win_o[15:0]), 512'(16'h0400));
      chk("t2_stall_in_ready", 512'(ifa.in_ready_o), 512'(0));
      step();
    end
    ifa.out_ready_i = 1'b1;
    @(negedge clk);
    chk("t2_release_row", 512'(ifa.out_row_o), 512'(2));
    step();
    @(negedge clk);
    chk("t2_next_row", 512'(ifa.out_row_o), 512'(3));
    chk("t2_next_win0", 512'(ifa.out_win_o[15:0]), 512'(16'h0800));
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    chk("t2_valid_done", 512'(ifa.out_valid_o), 512'(0));
    chk("t2_blk_cnt", 512'(blk_a), 512'(2));

    // T3: slide mode, A0..A8 carry values 1..9.
    slide = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_w0[k] = 16'(k + 1);
      send_a(23'(k + 1));
    end
    emit_a();
    chk("t3_blk_cnt_b1", 512'(blk_a), 512'(3));
    chk("t3_in_ready", 512'(ifa.in_ready_o), 512'(1));
    for (int k = 0; k < 8; k++) exp_w0[k] = 16'(k + 2);
    send_a(23'd9);
    slide = 1'b0;
    emit_a();
    chk("t3_blk_cnt_b2", 512'(blk_a), 512'(4));

    // T4: flush while showing row 4.
    for (int k = 0; k < 8; k++) send_a(23'(k + 32));
    ifa.out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    chk("t4_row_before_flush", 512'(ifa.out_row_o), 512'(4));
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("t4_flush_valid", 512'(ifa.out_valid_o), 512'(0));
    chk("t4_flush_in_ready", 512'(ifa.in_ready_o), 512'(1));
    chk("t4_flush_blk_cnt", 512'(blk_a), 512'(0));
    for (int k = 0; k < 8; k++) begin
      exp_w0[k] = 16'(k + 64);
      send_a(23'(k + 64));
    end
    emit_a();
    chk("t4_blk_cnt", 512'(blk_a), 512'(1));

    // T5: flush together with an input beat at count 3.
    for (int k = 0; k < 3; k++) send_a(23'(k + 80));
    ifa.in_valid_i = 1'b1;
    ifa.in_row_i   = 23'h99;
    flush = 1'b1;
    @(negedge clk);
    chk("t5_flush_in_ready", 512'(ifa.in_ready_o), 512'(0));
    step();
    flush = 1'b0;
    ifa.in_valid_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      exp_w0[k] = 16'(k + 96);
      send_a(23'(k + 96));
    end
    @(negedge clk);
    chk("t5_no_valid_after_7", 512'(ifa.out_valid_o), 512'(0));
    exp_w0[7] = 16'd103;
    send_a(23'd103);
    emit_a();
    chk("t5_blk_cnt", 512'(blk_a), 512'(1));

    // T6: reset mid-emit.
    for (int k = 0; k < 8; k++) send_a(23'(k + 112));
    ifa.out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    chk("t6_row_before_rst", 512'(ifa.out_row_o), 512'(3));
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("t6_rst_valid", 512'(ifa.out_valid_o), 512'(0));
    chk("t6_rst_in_ready", 512'(ifa.in_ready_o), 512'(0));
    chk("t6_rst_row", 512'(ifa.out_row_o), 512'(0));
    chk("t6_rst_last", 512'(ifa.out_last_o), 512'(0));
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("t6_post_valid", 512'(ifa.out_valid_o), 512'(0));
    chk("t6_post_in_ready", 512'(ifa.in_ready_o), 512'(1));
    chk("t6_post_blk_cnt", 512'(blk_a), 512'(0));

    // Second instance: 5 rows of 19 bytes, byte e of row r = r*32+e+1.
    for (int r = 0; r < 5; r++) begin
      for (int e = 0; e < 19; e++) rowb[e*8 +: 8] = 8'(r * 32 + e + 1);
      ifb.in_valid_i = 1'b1;
      ifb.in_row_i   = rowb;
      step();
      ifb.in_valid_i = 1'b0;
    end
    ifb.out_ready_i = 1'b1;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 16; i++) begin
        expw0[i*8 +: 8] = 8'(r * 32 + i + 1);
        expw3[i*8 +: 8] = 8'(r * 32 + 3 + i + 1);
      end
      @(negedge clk);
      chk("b_out_valid", 512'(ifb.out_valid_o), 512'(1));
      chk("b_out_row", 512'(ifb.out_row_o), 512'(r));
      chk("b_out_last", 512'(ifb.out_last_o), 512'(r == 4));
      chk("b_win_p0", 512'(ifb.out_win_o[127:0]), 512'(expw0));
      chk("b_win_p3", 512'(ifb.out_win_o[3*128 +: 128]), 512'(expw3));
      step();
    end
    @(negedge clk);
    chk("b_valid_done", 512'(ifb.out_valid_o), 512'(0));
    chk("b_blk_cnt", 512'(blk_b), 512'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
